// File: rtl/smd_pad_reader.sv
// Mega Drive pad reader: walks the six-button select sequence,
// samples the pad lines and publishes a decoded button snapshot.
module smd_pad_reader #(
  parameter int CLK_FREQ = 20000000,
  parameter int POLL_HZ  = 60,
  parameter int PHASE_US = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  p,
  output logic        p7,
  output logic [11:0] btn,
  output logic        six_btn,
  output logic        pad_present,
  output logic        valid,
  output logic        busy
);

  localparam int POLL_CYCLES = CLK_FREQ / POLL_HZ;
  localparam int SETTLE = CLK_FREQ / 1000000 * PHASE_US;
  localparam int CW = $clog2(POLL_CYCLES);
  localparam int SW = $clog2(SETTLE);
  localparam logic [CW-1:0] POLL_LAST = CW'(POLL_CYCLES - 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);

  typedef enum logic [1:0] {IDLE, PHASE, DONE} state_t;

  state_t state, state_n;

  logic [5:0]    p_s1, p_s2;
  logic [CW-1:0] poll_cnt;
  logic [SW-1:0] settle;
  logic [2:0]    k;
  logic          poll_hit;
  logic          start, sample, last;

  logic [5:0] h0;
  logic [3:0] l0;
  logic [3:0] l1, h2, l2;

  logic [11:0] dec_btn;
  logic        dec_six, dec_present;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_s1 <= 6'h3F;
      p_s2 <= 6'h3F;
    end else begin
      p_s1 <= p;
      p_s2 <= p_s1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      poll_cnt <= '0;
    else if (poll_hit)
      poll_cnt <= POLL_LAST;
    else
      poll_cnt <= poll_cnt - CW'(1);
  end

  assign poll_hit = (poll_cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_n;
  end

  always_comb begin
    state_n = state;
    start   = 1'b0;
    sample  = 1'b0;
    last    = 1'b0;
    unique case (state)
      IDLE: begin
        if (poll_hit) begin
          state_n = PHASE;
          start   = 1'b1;
        end
      end
      PHASE: begin
        if (settle == SETTLE_LAST) begin
          sample = 1'b1;
          if (k == 3'd7) begin
            state_n = DONE;
            last    = 1'b1;
          end
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state == PHASE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k      <= '0;
      settle <= '0;
      p7     <= 1'b1;
      h0     <= 6'h3F;
      l0     <= 4'hF;
      l1     <= 4'hF;
      h2     <= 4'hF;
      l2     <= 4'hF;
    end else if (start) begin
      k      <= '0;
      settle <= '0;
      p7     <= 1'b1;
    end else if (state == PHASE) begin
      if (sample) begin
        case (k)
          3'd0: h0 <= p_s2;
          3'd1: l0 <= p_s2[3:0];
          3'd3: l1 <= p_s2[5:2];
          3'd4: h2 <= p_s2[5:2];
          3'd5: l2 <= p_s2[5:2];
          default: ;
        endcase
        settle <= '0;
        // next phase index is k+1, so odd next phase drives select low
        if (last) begin
          p7 <= 1'b1;
        end else begin
          k  <= k + 3'd1;
          p7 <= k[0];
        end
      end else begin
        settle <= settle + SW'(1);
      end
    end
  end

  always_comb begin
    dec_present = (l0[3:2] == 2'b00);
    dec_six = dec_present && (l1 == 4'h0) && (l2 == 4'hF);
    dec_btn = 12'hFFF;
    if (dec_present) begin
      dec_btn = {4'hF, l0[0], h0[0], h0[1], l0[1],
                 h0[2], h0[3], h0[4], h0[5]};
      if (dec_six)
        dec_btn[11:8] = {h2[0], h2[3], h2[2], h2[1]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn         <= 12'hFFF;
      six_btn     <= 1'b0;
      pad_present <= 1'b0;
      valid       <= 1'b0;
    end else begin
      valid <= last;
      if (last) begin
        btn         <= dec_btn;
        six_btn     <= dec_six;
        pad_present <= dec_present;
      end
    end
  end

endmodule
